mem_dump: RTL

Readback engine for the instruction/data RAM: the counterpart of the ROM-to-RAM copy performed at boot. On a `start` pulse it reads `WORDS` consecutive 32-bit words from RAM port B, beginning at `BASE_ADDR`, and streams them out over a valid/ready interface for a UART bridge or a testbench scoreboard. It shares the RAM port-B address/write-enable mux with the loader and the datapath, and is only granted the port while the datapath is held in reset.

---
 rtl/mem_dump_if.sv | 25 ++
 rtl/mem_dump.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mem_dump_if.sv
// mem_dump_if: RAM port-B and output stream signals of the readback engine.
//   RAM_Addr  engine -> RAM   byte address (bits [11:2] used by the RAM)
//   RAM_Data  RAM -> engine   read data, updated on the RAM's falling-edge read
//   MemRW     engine -> RAM   write enable (the engine never writes)
//   out_data  engine -> sink  stream word
//   out_valid engine -> sink  out_data is valid
//   out_ready sink -> engine  sink accepts when high together with out_valid
interface mem_dump_if;
  logic [31:0] RAM_Addr;
  logic [31:0] RAM_Data;
  logic        MemRW;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output RAM_Addr, MemRW, out_data, out_valid,
    input  RAM_Data, out_ready
  );

  modport slave (
    input  RAM_Addr, MemRW, out_data, out_valid,
    output RAM_Data, out_ready
  );
endinterface

// File: rtl/mem_dump.sv
// mem_dump: reads WORDS consecutive 32-bit words from RAM port B starting at
// BASE_ADDR and streams them over a valid/ready interface.
// Ports:
//   clk    system clock, rising edge
//   rst    asynchronous active-low reset
//   start  level, sampled in IDLE; a held start yields only one dump
//   busy   high in ISSUE/CAPTURE/SEND
//   done   high in DONE
//   bus    mem_dump_if.master: RAM_Addr/RAM_Data/MemRW, out_data/valid/ready
// Optional feature macro: MEM_DUMP_CHECKSUM_EN appends a mod-2^32 sum of the
// data words as one extra trailer beat before DONE.
module mem_dump #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          WORDS     = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  mem_dump_if.master  bus
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   data_q, data_d;

`ifdef MEM_DUMP_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
  logic        trail_q, trail_d;   // current SEND beat is the checksum trailer
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
`ifdef MEM_DUMP_CHECKSUM_EN
    sum_d   = sum_q;
    trail_d = trail_q;
`endif
    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (start) begin
          state_d = S_ISSUE;
`ifdef MEM_DUMP_CHECKSUM_EN
          sum_d   = '0;
          trail_d = 1'b0;
`endif
        end
      end
      S_ISSUE:   state_d = S_CAPTURE;
      S_CAPTURE: begin
        data_d  = bus.RAM_Data;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (bus.out_ready) begin
`ifdef MEM_DUMP_CHECKSUM_EN
          if (trail_q) begin
            state_d = S_DONE;
          end else begin
            sum_d = sum_q + data_q;
            if (idx_q == LAST) begin
              // stay in SEND and present the sum as the trailer beat
              trail_d = 1'b1;
              data_d  = sum_q + data_q;
            end else begin
              idx_d   = idx_q + IW'(1);
              state_d = S_ISSUE;
            end
          end
`else
          if (idx_q == LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = S_ISSUE;
          end
`endif
        end
      end
      S_DONE: begin
        if (!start) begin
          state_d = S_IDLE;
          idx_d   = '0;   // so RAM_Addr already reads BASE_ADDR in IDLE
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

`ifdef MEM_DUMP_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q   <= '0;
      trail_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      trail_q <= trail_d;
    end
  end
`endif

  // Address follows the registered index; it is stable through ISSUE and
  // CAPTURE so the falling-edge RAM read lands inside the window.
  assign bus.RAM_Addr  = BASE_ADDR + (32'(idx_q) << 2);
  assign bus.MemRW     = 1'b0;
  assign bus.out_data  = data_q;
  assign bus.out_valid = (state_q == S_SEND);
  assign busy = (state_q == S_ISSUE) || (state_q == S_CAPTURE) || (state_q == S_SEND);
  assign done = (state_q == S_DONE);

endmodule
